// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Purpose  : Shared AHB-Lite encodings and slave state type.
// Revision : 1.0
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_e;

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_byte_strobe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ahb_byte_strobe
// Purpose  : Size + low address bits to byte-lane strobe and alignment error.
// Revision : 1.0
// ============================================================================
module ahb_byte_strobe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                        size_in,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   addr_lo_in,
    output logic [DATA_WIDTH/8-1:0]           strobe_out,
    output logic                              err_out
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(NUM_LANES);

    int lane_lo;
    int size_bytes;

    always_comb begin
        lane_lo    = int'(addr_lo_in);
        size_bytes = 1 << size_in;
        err_out    = (int'(size_in) > LANE_BITS) || ((lane_lo & (size_bytes - 1)) != 0);
        strobe_out = '0;
        for (int b = 0; b < NUM_LANES; b++) begin
            strobe_out[b] = !err_out && (b >= lane_lo) && (b < lane_lo + size_bytes);
        end
    end

endmodule : ahb_byte_strobe
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ahb_sram_slave
// Purpose  : AHB-Lite SRAM responder with wait states, byte lanes and ERROR.
// Revision : 1.0
// ============================================================================
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int WAIT_STATES   = 0,
    parameter int WRITE_PROTECT = 0
) (
    input  logic                  hclk_in,
    input  logic                  hresetn_in,
    input  logic [ADDR_WIDTH-1:0] haddr_in,
    input  logic [DATA_WIDTH-1:0] hwdata_in,
    output logic [DATA_WIDTH-1:0] hrdata_out,
    input  logic                  hsel_in,
    input  logic                  hwrite_in,
    input  logic [1:0]            htrans_in,
    input  logic [2:0]            hsize_in,
    input  logic [2:0]            hburst_in,
    input  logic [3:0]            hprot_in,
    input  logic                  hmastlock_in,
    input  logic                  hready_in,
    output logic                  hreadyout_out,
    output logic                  hresp_out
);

    localparam int         NUM_LANES = DATA_WIDTH / 8;
    localparam int         LANE_BITS = $clog2(NUM_LANES);
    localparam int         IDX_BITS  = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slave_state_e          state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic                  write_q, write_d;
    logic [NUM_LANES-1:0]  strb_q, strb_d;

    logic [NUM_LANES-1:0]  strb_w;
    logic                  size_err_w;
    logic                  accept_w;
    logic                  xfer_err_w;
    logic                  unused_inputs;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    ahb_byte_strobe #(.DATA_WIDTH(DATA_WIDTH)) u_strobe (
        .size_in    (hsize_in),
        .addr_lo_in (haddr_in[LANE_BITS-1:0]),
        .strobe_out (strb_w),
        .err_out    (size_err_w)
    );

    assign accept_w      = hsel_in & htrans_in[1] & hready_in;
    assign xfer_err_w    = size_err_w | (hwrite_in & (WRITE_PROTECT != 0));
    assign unused_inputs = ^{hburst_in, hprot_in, hmastlock_in, htrans_in[0],
                             haddr_in[ADDR_WIDTH-1:LANE_BITS+IDX_BITS]};

    always_ff @(posedge hclk_in or negedge hresetn_in) begin
        if (!hresetn_in) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            strb_q     <= strb_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        idx_d         = idx_q;
        write_d       = write_q;
        strb_d        = strb_q;
        hreadyout_out = 1'b1;
        hresp_out     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: begin
                hreadyout_out = 1'b0;
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                hreadyout_out = 1'b0;
                hresp_out     = HRESP_ERROR;
                state_d       = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all complete this cycle and may take a new transfer
                if (state_q == ST_ERR2) begin
                    hresp_out = HRESP_ERROR;
                end
                state_d = ST_IDLE;
                if (accept_w) begin
                    idx_d   = haddr_in[LANE_BITS +: IDX_BITS];
                    write_d = hwrite_in;
                    strb_d  = strb_w;
                    if (xfer_err_w) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    // Write commits at the edge closing the data phase, so a following read sees it in the array.
    always_ff @(posedge hclk_in) begin
        if (state_q == ST_DATA && write_q) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= hwdata_in[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        hrdata_out = '0;
        if (state_q == ST_DATA && !write_q) begin
            hrdata_out = mem[idx_q];
        end
    end

endmodule : ahb_sram_slave
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ahb_sram_slave
// Purpose  : Directed scoreboard bench over four slave configurations.
// Revision : 1.0
// ============================================================================
module tb_ahb_sram_slave;

    typedef struct {
        int          inst;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
        string       tag;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        resp;
        int          low;
        string       tag;
    } exp_t;

    logic        hclk_in = 1'b0;
    logic        hresetn_in;
    logic [31:0] haddr_in;
    logic [31:0] hwdata_in;
    logic        hwrite_in;
    logic [1:0]  htrans_in;
    logic [2:0]  hsize_in;
    logic [3:0]  hsel_v;
    logic [3:0]  hreadyout_v;
    logic [3:0]  hresp_v;
    logic [31:0] rdata_v [4];
    logic        hready_bus;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_rdata;
    logic [31:0] prior;

    req_t reqq[$];
    exp_t expq[$];

    // instance 0: WS=0, 1: WS=3, 2: WS=5, 3: WS=0 with write protect
    int ws_of [4] = '{0, 3, 5, 0};
    int wp_of [4] = '{0, 0, 0, 1};

    assign hready_bus = &hreadyout_v;

    always #5 hclk_in = ~hclk_in;

    ahb_sram_slave #(.WAIT_STATES(0), .WRITE_PROTECT(0)) u_ws0 (
        .hclk_in(hclk_in), .hresetn_in(hresetn_in), .haddr_in(haddr_in), .hwdata_in(hwdata_in),
        .hrdata_out(rdata_v[0]), .hsel_in(hsel_v[0]), .hwrite_in(hwrite_in), .htrans_in(htrans_in),
        .hsize_in(hsize_in), .hburst_in(3'd0), .hprot_in(4'd0), .hmastlock_in(1'b0),
        .hready_in(hready_bus), .hreadyout_out(hreadyout_v[0]), .hresp_out(hresp_v[0]));

    ahb_sram_slave #(.WAIT_STATES(3), .WRITE_PROTECT(0)) u_ws3 (
        .hclk_in(hclk_in), .hresetn_in(hresetn_in), .haddr_in(haddr_in), .hwdata_in(hwdata_in),
        .hrdata_out(rdata_v[1]), .hsel_in(hsel_v[1]), .hwrite_in(hwrite_in), .htrans_in(htrans_in),
        .hsize_in(hsize_in), .hburst_in(3'd0), .hprot_in(4'd0), .hmastlock_in(1'b0),
        .hready_in(hready_bus), .hreadyout_out(hreadyout_v[1]), .hresp_out(hresp_v[1]));

    ahb_sram_slave #(.WAIT_STATES(5), .WRITE_PROTECT(0)) u_ws5 (
        .hclk_in(hclk_in), .hresetn_in(hresetn_in), .haddr_in(haddr_in), .hwdata_in(hwdata_in),
        .hrdata_out(rdata_v[2]), .hsel_in(hsel_v[2]), .hwrite_in(hwrite_in), .htrans_in(htrans_in),
        .hsize_in(hsize_in), .hburst_in(3'd0), .hprot_in(4'd0), .hmastlock_in(1'b0),
        .hready_in(hready_bus), .hreadyout_out(hreadyout_v[2]), .hresp_out(hresp_v[2]));

    ahb_sram_slave #(.WAIT_STATES(0), .WRITE_PROTECT(1)) u_wp (
        .hclk_in(hclk_in), .hresetn_in(hresetn_in), .haddr_in(haddr_in), .hwdata_in(hwdata_in),
        .hrdata_out(rdata_v[3]), .hsel_in(hsel_v[3]), .hwrite_in(hwrite_in), .htrans_in(htrans_in),
        .hsize_in(hsize_in), .hburst_in(3'd0), .hprot_in(4'd0), .hmastlock_in(1'b0),
        .hready_in(hready_bus), .hreadyout_out(hreadyout_v[3]), .hresp_out(hresp_v[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int inst, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic chk, input string tag);
        req_t r;
        r.inst = inst; r.trans = trans; r.wr = wr; r.size = size; r.addr = addr;
        r.wdata = wdata; r.exp_rdata = exp_rdata; r.chk_rdata = chk; r.tag = tag;
        reqq.push_back(r);
    endtask

    task automatic bus_idle();
        hsel_v    = 4'b0000;
        htrans_in = 2'b00;
        hwrite_in = 1'b0;
        hsize_in  = 3'd2;
        haddr_in  = 32'h0;
    endtask

    // Called at a falling edge; runs queued transfers pipelined, one address phase per ready cycle.
    task automatic run_bus(input int max_cycles);
        req_t dp;
        exp_t e;
        bit   have_dp = 1'b0;
        bit   err;
        int   low = 0;
        int   cyc = 0;
        while ((reqq.size() > 0 || have_dp) && cyc < max_cycles) begin
            if (have_dp) begin
                hwdata_in = dp.wdata;
                if (hready_bus) begin
                    e = expq.pop_front();
                    check({e.tag, "_resp"}, 64'(hresp_v[dp.inst]), 64'(e.resp));
                    check({e.tag, "_lowcycles"}, 64'(low), 64'(e.low));
                    if (e.chk_rdata) check({e.tag, "_rdata"}, 64'(rdata_v[dp.inst]), 64'(e.rdata));
                    last_rdata = rdata_v[dp.inst];
                    have_dp = 1'b0;
                end else begin
                    low++;
                    check({expq[0].tag, "_lowresp"}, 64'(hresp_v[dp.inst]), 64'(expq[0].resp));
                    check({expq[0].tag, "_lowrdata"}, 64'(rdata_v[dp.inst]), 64'h0);
                end
            end
            if (hready_bus) begin
                if (reqq.size() > 0) begin
                    dp = reqq.pop_front();
                    have_dp = 1'b1;
                    low = 0;
                    hsel_v = 4'b0000;
                    hsel_v[dp.inst] = 1'b1;
                    htrans_in = dp.trans;
                    hwrite_in = dp.wr;
                    hsize_in  = dp.size;
                    haddr_in  = dp.addr;
                    err = (dp.size > 3'd2) || ((dp.addr & ((32'd1 << dp.size) - 32'd1)) != 32'd0)
                          || (dp.wr && wp_of[dp.inst] != 0);
                    e.resp      = err;
                    e.low       = err ? 1 : ws_of[dp.inst];
                    e.rdata     = (err || dp.wr) ? 32'h0 : dp.exp_rdata;
                    e.chk_rdata = (err || dp.wr) ? 1'b1 : dp.chk_rdata;
                    e.tag       = dp.tag;
                    expq.push_back(e);
                end else begin
                    bus_idle();
                end
            end
            @(negedge hclk_in);
            cyc++;
        end
        check("bus_timeout", 64'(reqq.size() + int'(have_dp)), 64'h0);
        bus_idle();
        reqq.delete();
        expq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hresetn_in = 1'b0;
        hwdata_in  = 32'h0;
        bus_idle();
        repeat (2) @(negedge hclk_in);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_hreadyout%0d", i), 64'(hreadyout_v[i]), 64'h1);
            check($sformatf("reset_hresp%0d", i), 64'(hresp_v[i]), 64'h0);
            check($sformatf("reset_hrdata%0d", i), 64'(rdata_v[i]), 64'h0);
        end
        hresetn_in = 1'b1;
        @(negedge hclk_in);

        // word write then read, zero wait
        add(0, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1, "w0_write10");
        add(0, 2'b10, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1, "w0_read10");
        // byte and halfword lanes
        add(0, 2'b10, 1, 3'd2, 32'h20, 32'h11223344, 32'h0, 1, "lane_word20");
        add(0, 2'b10, 1, 3'd0, 32'h22, 32'h00AA0000, 32'h0, 1, "lane_byte22");
        add(0, 2'b10, 0, 3'd2, 32'h20, 32'h0, 32'h11AA3344, 1, "lane_read20");
        add(0, 2'b10, 1, 3'd2, 32'h24, 32'h00000000, 32'h0, 1, "lane_word24");
        add(0, 2'b10, 1, 3'd1, 32'h26, 32'hBEEF0000, 32'h0, 1, "lane_half26");
        add(0, 2'b10, 1, 3'd0, 32'h24, 32'h0000005A, 32'h0, 1, "lane_byte24");
        add(0, 2'b10, 0, 3'd2, 32'h24, 32'h0, 32'hBEEF005A, 1, "lane_read24");
        run_bus(100);

        // misaligned / oversize errors leave memory untouched
        add(0, 2'b10, 1, 3'd2, 32'h00, 32'h01020304, 32'h0, 1, "err_init00");
        add(0, 2'b10, 1, 3'd2, 32'h02, 32'hFFFFFFFF, 32'h0, 1, "err_word02");
        add(0, 2'b10, 1, 3'd1, 32'h01, 32'hFFFFFFFF, 32'h0, 1, "err_half01");
        add(0, 2'b10, 1, 3'd3, 32'h00, 32'hFFFFFFFF, 32'h0, 1, "err_dword00");
        add(0, 2'b10, 0, 3'd2, 32'h00, 32'h0, 32'h01020304, 1, "err_read00");
        run_bus(100);

        // wait states with back-to-back SEQ reads
        add(1, 2'b10, 1, 3'd2, 32'h40, 32'hCAFEF00D, 32'h0, 1, "ws3_write40");
        add(1, 2'b11, 1, 3'd2, 32'h44, 32'h0BADC0DE, 32'h0, 1, "ws3_write44");
        add(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 1, "ws3_read40");
        add(1, 2'b11, 0, 3'd2, 32'h44, 32'h0, 32'h0BADC0DE, 1, "ws3_read44");
        run_bus(200);

        // write protect: value before and after the rejected write must match
        add(3, 2'b10, 0, 3'd2, 32'h30, 32'h0, 32'h0, 0, "wp_read30_pre");
        run_bus(50);
        prior = last_rdata;
        add(3, 2'b10, 1, 3'd2, 32'h30, 32'h12345678, 32'h0, 1, "wp_write30");
        add(3, 2'b10, 0, 3'd2, 32'h30, 32'h0, prior, 1, "wp_read30_post");
        run_bus(50);

        // reset while a write sits in its wait states
        add(2, 2'b10, 1, 3'd2, 32'h50, 32'h55AA55AA, 32'h0, 1, "ws5_write50");
        run_bus(100);
        hsel_v = 4'b0100; htrans_in = 2'b10; hwrite_in = 1'b1; hsize_in = 3'd2; haddr_in = 32'h50;
        @(negedge hclk_in);
        bus_idle();
        hwdata_in = 32'hFFFFFFFF;
        check("rstwait_cycle1_hreadyout", 64'(hreadyout_v[2]), 64'h0);
        @(negedge hclk_in);
        hresetn_in = 1'b0;
        #1;
        check("rstwait_hreadyout", 64'(hreadyout_v[2]), 64'h1);
        check("rstwait_hresp", 64'(hresp_v[2]), 64'h0);
        check("rstwait_hrdata", 64'(rdata_v[2]), 64'h0);
        repeat (2) @(negedge hclk_in);
        hresetn_in = 1'b1;
        @(negedge hclk_in);
        add(2, 2'b10, 0, 3'd2, 32'h50, 32'h0, 32'h55AA55AA, 1, "rstwait_read50");
        run_bus(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ahb_sram_slave
`default_nettype wire

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder at the slave end of the AHB bus matrix, wrapping an internal word-organised RAM array.
- Connects to one slave port of the matrix. It receives that port's hsel, htrans and address/control signals plus the broadcast HREADY, and returns HREADYOUT, HRESP and HRDATA.
- Provides configurable wait states, byte/halfword/word access with byte-lane writes, optional write protection, and the two-cycle ERROR response.

Parameters:
- DATA_WIDTH, 32, bus data width; 32 or 64 supported.
- ADDR_WIDTH, 32, bus address width.
- MEM_DEPTH, 1024, number of DATA_WIDTH words; must be a power of two.
- WAIT_STATES, 0, wait cycles inserted before each OKAY completion; range 0..15.
- WRITE_PROTECT, 0, when 1 every write returns ERROR and memory is unchanged.

Ports:
- hclk_in  input  1  bus clock; all state updates on rising edge.
- hresetn_in  input  1  reset, asynchronous, active-low.
- haddr_in  input  ADDR_WIDTH  address phase address.
- hwdata_in  input  DATA_WIDTH  write data, valid in data phase.
- hrdata_out  output  DATA_WIDTH  read data.
- hsel_in  input  1  slave select from matrix decoder.
- hwrite_in  input  1  1 = write, 0 = read.
- htrans_in  input  2  IDLE/BUSY/NONSEQ/SEQ.
- hsize_in  input  3  transfer size (0 = byte, 1 = half, 2 = word, 3 = dword).
- hburst_in  input  3  ignored.
- hprot_in  input  4  ignored.
- hmastlock_in  input  1  ignored.
- hready_in  input  1  bus HREADY (previous transfer complete).
- hreadyout_out  output  1  slave ready.
- hresp_out  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = ST_IDLE, hreadyout_out = 1, hresp_out = 0, hrdata_out = 0, wait counter = 0.
  - Any pending write is dropped.
  - RAM contents are not reset.
- Address phase is accepted on a rising edge where hsel_in & htrans_in[1] & hready_in = 1.
  - On acceptance, latch: addr, write, size, word index = addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)].
  - Higher address bits are ignored; the matrix decodes range.
- IDLE/BUSY transfers, or hsel_in = 0 with hready_in = 1: next state ST_IDLE, zero-wait OKAY.
- Error detection at acceptance. Any of the following gives an error:
  - hsize_in > log2(DATA_WIDTH/8);
  - address not aligned to hsize_in;
  - write with WRITE_PROTECT = 1.
- States:
  - ST_IDLE: hreadyout = 1, hresp = 0. On acceptance go to ST_ERR1 if error; else ST_WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES-1); else ST_DATA.
  - ST_WAIT: hreadyout = 0, hresp = 0. Counter decrements each cycle; at 0 go to ST_DATA. Exactly WAIT_STATES low cycles.
  - ST_DATA: hreadyout = 1, hresp = 0, transfer completes this cycle.
    - Write: bytes enabled by the strobe from latched size and addr low bits are written from hwdata_in at this edge.
    - Read: hrdata_out = array word at latched index, full word, unmasked.
    - The same edge evaluates a new acceptance (pipelined back-to-back); otherwise go to ST_IDLE.
  - ST_ERR1: hreadyout = 0, hresp = 1, then ST_ERR2.
  - ST_ERR2: hreadyout = 1, hresp = 1; no memory write. Evaluates a new acceptance like ST_DATA.
- Read data:
  - The array is read asynchronously at the latched index during ST_DATA.
  - A read immediately following a write to the same word returns the newly written bytes. Forward hwdata under strobe if the array read precedes the commit.
  - hrdata_out = 0 in all states other than read ST_DATA.
- hready_in = 0 while this slave is in ST_IDLE: nothing is sampled; outputs hold.
- A new address phase is never accepted in ST_WAIT/ST_ERR1, because hready_in is low then.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  - HRESP_OKAY = 0, HRESP_ERROR = 1;
  - HSIZE_BYTE/HALF/WORD/DWORD constants;
  - slave state encoding ST_IDLE/ST_WAIT/ST_DATA/ST_ERR1/ST_ERR2.
- Sub-module ahb_byte_strobe: combinational; (size, addr low bits) -> DATA_WIDTH/8 byte strobe plus misalign/oversize error flag. Reused by future AHB slaves.

Test Plan:
- Word write then read, WAIT_STATES = 0: NONSEQ write 0x0000_0010 data 0xDEADBEEF, next cycle NONSEQ read 0x10 -> write completes in 1 cycle; read returns 0xDEADBEEF, hresp = 0, hreadyout never low.
- Byte lanes: write word 0x11223344 at 0x20, byte write 0xAA at 0x22 (hwdata = 0x00AA0000) -> read of 0x20 returns 0x11AA3344.
- Wait states, WAIT_STATES = 3: single read -> hreadyout low exactly 3 cycles after address phase, then high with data; back-to-back SEQ reads each take 4 data cycles.
- Misaligned: hsize = 2 at address 0x02 -> hreadyout 0/hresp 1, then hreadyout 1/hresp 1; memory unchanged; subsequent aligned read OKAY.
- WRITE_PROTECT = 1: word write 0x12345678 to 0x30 -> two-cycle ERROR; read of 0x30 returns the prior value.
- Reset in ST_WAIT (WAIT_STATES = 5, write in flight, hresetn_in low at wait cycle 2) -> outputs immediately hreadyout = 1, hresp = 0, hrdata = 0; target word not modified.
